// File: rtl/add_pkg.sv
// add_pkg: shared state encoding for the multicycle adder
package add_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/add_chunk.sv
// add_chunk: CHUNK-wide combinational ripple adder exposing the carry into the MSB
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);
    logic [CHUNK:0] w_c;
    // ripple the carry bit by bit so the carry into the top bit is visible
    always_comb begin
        w_c    = '0;
        w_c[0] = ci;
        s      = '0;
        for (int k = 0; k < CHUNK; k++) begin
            s[k]     = a[k] ^ b[k] ^ w_c[k];
            w_c[k+1] = (a[k] & b[k]) | (w_c[k] & (a[k] ^ b[k]));
        end
    end
    assign co       = w_c[CHUNK];
    assign c_msb_in = w_c[CHUNK-1];
endmodule

// File: rtl/add_multicycle.sv
// add_multicycle: adds/subtracts WIDTH-bit operands CHUNK bits per cycle with one reused chunk adder
module add_multicycle
    import add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic             zr,
    output logic             ng
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    state_t           r_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_c;
    logic             r_sub;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zr;
    logic             r_ng;
    logic             r_out_valid;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_s;
    logic             w_ci;
    logic             w_co;
    logic             w_cm;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;
    assign in_ready = (r_state == IDLE) && rst_n;
    assign w_last   = (r_idx == IW'(N - 1));
    // subtraction always forces the first chunk's carry-in to 1
    assign w_ci     = (r_idx == '0) ? (r_c | r_sub) : r_c;
    // select the current chunk of both captured operands and splice its result into the sum
    always_comb begin
        w_a        = r_x[r_idx*CHUNK +: CHUNK];
        w_b        = r_y[r_idx*CHUNK +: CHUNK];
        w_sum_next = r_sum;
        w_sum_next[r_idx*CHUNK +: CHUNK] = w_s;
    end
    add_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (w_a),
        .b        (w_b),
        .ci       (w_ci),
        .s        (w_s),
        .co       (w_co),
        .c_msb_in (w_cm)
    );
    // control FSM plus operand, partial-sum and flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_c         <= 1'b0;
            r_sub       <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zr        <= 1'b0;
            r_ng        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x     <= x;
                        r_y     <= sub ? ~y : y;
                        r_c     <= sub | cin;
                        r_sub   <= sub;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum <= w_sum_next;
                    r_c   <= w_co;
                    r_idx <= w_last ? '0 : r_idx + IW'(1);
                    if (w_last) begin
                        r_carry     <= w_co;
                        r_ovf       <= w_cm ^ w_co;
                        r_zr        <= (w_sum_next == '0);
                        r_ng        <= w_sum_next[WIDTH-1];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign zr        = r_zr;
    assign ng        = r_ng;
endmodule

// File: tb/tb_add_multicycle.sv
// tb_add_multicycle: directed vectors against a 16/4 instance and an 8/8 single-cycle instance
module tb_add_multicycle;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
    logic        zr;
    logic        ng;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_x;
    logic [7:0]  b_y;
    logic        b_cin;
    logic        b_sub;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [7:0]  b_sum;
    logic        b_carry;
    logic        b_ovf;
    logic        b_zr;
    logic        b_ng;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    add_multicycle #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .ovf(ovf), .zr(zr), .ng(ng)
    );

    add_multicycle #(.WIDTH(8), .CHUNK(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .x(b_x), .y(b_y), .cin(b_cin), .sub(b_sub), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sum(b_sum), .carry(b_carry), .ovf(b_ovf), .zr(b_zr), .ng(b_ng)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // accept one operation, scramble the inputs during RUN, check latency, results, then handshake
    task automatic run_op(input string tag, input logic [15:0] ox, input logic [15:0] oy,
                          input logic oc, input logic os, input logic [15:0] e_sum,
                          input logic e_c, input logic e_ovf, input logic e_zr, input logic e_ng,
                          input int hold);
        int          cycles;
        logic [15:0] held;
        @(negedge clk);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        x = ox; y = oy; cin = oc; sub = os;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = ~ox; y = ~oy; cin = ~oc; sub = ~os;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk({tag, ".latency"}, 32'(cycles), 32'd4);
        chk({tag, ".sum"}, 32'(sum), 32'(e_sum));
        chk({tag, ".carry"}, 32'(carry), 32'(e_c));
        chk({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
        chk({tag, ".zr"}, 32'(zr), 32'(e_zr));
        chk({tag, ".ng"}, 32'(ng), 32'(e_ng));
        held = sum;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_sum"}, 32'(sum), 32'(held));
            chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; cin = 1'b0; sub = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        b_x = '0; b_y = '0; b_cin = 1'b0; b_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.flags", {28'd0, carry, ovf, zr, ng}, 32'd0);
        chk("rst.sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle.in_ready", 32'(in_ready), 32'd1);

        run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        run_op("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        run_op("cin",     16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op("ripple",  16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        run_op("bp",      16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 5);

        @(negedge clk);
        in_valid = 1'b1; x = 16'hABCD; y = 16'h1111; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd0);
        chk("midrst.sum", 32'(sum), 32'd0);
        chk("midrst.flags", {28'd0, carry, ovf, zr, ng}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst.no_valid", 32'(seen), 32'd0);
        run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        @(negedge clk);
        b_in_valid = 1'b1; b_x = 8'h80; b_y = 8'h80; b_cin = 1'b0; b_sub = 1'b0;
        chk("n1.in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_x = 8'h01; b_y = 8'h01;
        seen = 0;
        while (!b_out_valid && seen < 20) begin
            @(posedge clk); #1;
            seen++;
        end
        chk("n1.latency", 32'(seen), 32'd1);
        chk("n1.sum", 32'(b_sum), 32'h00);
        chk("n1.carry", 32'(b_carry), 32'd1);
        chk("n1.ovf", 32'(b_ovf), 32'd1);
        chk("n1.zr", 32'(b_zr), 32'd1);
        @(posedge clk); #1;
        chk("n1.post_in_ready", 32'(b_in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/add_multicycle.md
ADD_MULTICYCLE -- requirements
Module: add_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, meaning bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous reset, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-007 The block SHALL have ports x and y, input, WIDTH bits: the operands.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 = x+y+cin; 1 = x-y (x + ~y + 1; cin ignored).
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-013 The block SHALL have port carry, output, 1 bit: carry out of the MSB (in sub mode, 1 = no borrow).
REQ-014 The block SHALL have ports ovf, zr and ng, output, 1 bit each: signed overflow, sum==0, and sum[WIDTH-1].

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE with rst_n=1, combinationally.
REQ-016 IDLE->RUN on in_valid&&in_ready: the block SHALL register x, y (inverted if sub), the effective carry-in (cin or 1) and sub; the chunk index SHALL clear to 0.
REQ-017 Each RUN cycle SHALL add chunk i of the captured operands with the registered carry, write sum[i*CHUNK +: CHUNK], register the chunk carry-out, and increment i.
REQ-018 After chunk N-1 is written, the FSM SHALL enter DONE; out_valid SHALL be 1 exactly N cycles after the acceptance edge.
REQ-019 In DONE the block SHALL assert out_valid and hold sum/carry/ovf/zr/ng stable until out_valid&&out_ready; on that edge it SHALL go to IDLE.
REQ-020 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB; zr and ng SHALL be derived from the final sum.
REQ-021 The block SHALL have no overlap: the next operands are accepted no earlier than the cycle after the DONE handshake; the throughput is one operation per N+2 cycles with out_ready held at 1.
REQ-022 Inputs x/y/cin/sub SHALL be ignored outside the acceptance edge; changes during RUN SHALL NOT affect the result.
REQ-023 With N=1 (CHUNK=WIDTH), the block SHALL behave identically with a latency of 1.
REQ-024 While out_valid is 0, the values of sum and the flags SHALL be undefined for checking, except after reset.

Reset
REQ-025 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear the operand registers, sum, carry, ovf, zr, ng, out_valid and the chunk index to 0.
REQ-026 A reset mid-RUN or in DONE SHALL discard the operation, and no out_valid SHALL follow it.

Structure
REQ-027 The state encodings (IDLE=0, RUN=1, DONE=2) SHALL be defined in the shared package add_pkg.
REQ-028 The block SHALL instantiate a CHUNK-wide combinational ripple adder, add_chunk (a, b, ci -> s, co, c_msb_in); a single instance SHALL be reused every RUN cycle.
REQ-029 The block SHALL implement the chunk mux and write by index; it SHALL NOT unroll N adders.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-030 The bench SHALL drive x=0x7FFF, y=0x0001, sub=0, cin=0 -> after 4 cycles: sum=0x8000, carry=0, ovf=1, ng=1, zr=0.
REQ-031 The bench SHALL drive x=0xFFFF, y=0x0001, cin=0 -> sum=0x0000, carry=1, ovf=0, zr=1; then x=0x1234, y=0x0000, cin=1 -> sum=0x1235.
REQ-032 The bench SHALL drive sub=1, x=0x0005, y=0x0007, cin=1 -> sum=0xFFFE, carry=0, ng=1, ovf=0; and x=0x8000, y=0x0001 -> sum=0x7FFF, ovf=1, carry=1.
REQ-033 Backpressure: the bench SHALL hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0; on release, in_ready=1 the next cycle.
REQ-034 Reset mid-operation: the bench SHALL pull rst_n=0 at RUN chunk 2 -> next cycle IDLE, all outputs 0, no out_valid; a new operation completes correctly.
REQ-035 With WIDTH=8, CHUNK=8, the bench SHALL drive x=0x80, y=0x80 -> out_valid 1 cycle after acceptance, sum=0x00, carry=1, ovf=1, zr=1.
